// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial arithmetic cells: FSM state encoding and default width.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out bo.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bin;
    assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first unsigned subtractor diff = a - b over WIDTH cycles with start/done handshake.
// Optional signed overflow output enabled by defining SERIAL_SUB_SIGNED_OVF_EN.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state_r;
    state_e             state_next_s;
    logic [WIDTH-1:0]   sa_r;
    logic [WIDTH-1:0]   sb_r;
    logic [WIDTH-1:0]   diff_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               borrow_r;
    logic               bout_r;
    logic               busy_r;
    logic               done_r;
    logic               busy_next_s;
    logic               done_next_s;
    logic               d_s;
    logic               bnext_s;
    logic               last_bit_s;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic               ovf_r;
`endif

    full_subtractor u_cell (
        .a   (sa_r[0]),
        .b   (sb_r[0]),
        .bin (borrow_r),
        .d   (d_s),
        .bo  (bnext_s)
    );

    assign last_bit_s = (state_r == SHIFT) && (cnt_r == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; start outside IDLE is dropped, not queued
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_bit_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode from the next state so busy/done come straight from flops
    always_comb begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
        case (state_next_s)
            SHIFT:   busy_next_s = 1'b1;
            DONE:    done_next_s = 1'b1;
            default: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_next_s;
            done_r <= done_next_s;
        end
    end

    // Operand capture and serial datapath; diff/bout hold outside SHIFT
    always_ff @(posedge clk) begin
        if (rst) begin
            sa_r     <= {WIDTH{1'b0}};
            sb_r     <= {WIDTH{1'b0}};
            diff_r   <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            borrow_r <= 1'b0;
            bout_r   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            ovf_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        sa_r     <= a;
                        sb_r     <= b;
                        borrow_r <= 1'b0;
                        cnt_r    <= {CNT_W{1'b0}};
                    end
                end
                SHIFT: begin
                    diff_r   <= {d_s, diff_r[WIDTH-1:1]};
                    sa_r     <= {1'b0, sa_r[WIDTH-1:1]};
                    sb_r     <= {1'b0, sb_r[WIDTH-1:1]};
                    borrow_r <= bnext_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (last_bit_s) begin
                        bout_r <= bnext_s;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                        // borrow_r here is the borrow into the MSB cell
                        ovf_r  <= borrow_r ^ bnext_s;
`endif
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign diff = diff_r;
    assign bout = bout_r;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    assign ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); ovf checked when SERIAL_SUB_SIGNED_OVF_EN is defined.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic       ovf;
`endif

    int vectors     = 0;
    int miscompares = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction; samples every negedge from the start edge onward (k = edges after the start edge)
    task automatic run_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                          input logic [7:0] exp_diff, input logic exp_bout, input logic exp_ovf,
                          input bit poke);
        int         busy_cnt = 0;
        int         done_cnt = 0;
        int         done_k   = -1;
        logic [7:0] got_diff = 8'h00;
        logic       got_bout = 1'b0;
        logic       got_ovf  = 1'b0;
        @(negedge clk);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            if (k == 1) begin
                a = ~op_a;
                b = op_a;
            end
            if (poke && k == 2) begin
                start = 1'b1;
                a     = 8'h01;
                b     = 8'hF0;
            end
            if (poke && k == 4) start = 1'b0;
            busy_cnt += int'(busy);
            if (done) begin
                done_cnt++;
                done_k   = k;
                got_diff = diff;
                got_bout = bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                got_ovf  = ovf;
`else
                got_ovf  = exp_ovf;
`endif
            end
        end
        check({tag, " busy_cycles"}, busy_cnt, 32'd8);
        check({tag, " done_pulses"}, done_cnt, 32'd1);
        check({tag, " done_latency"}, done_k, 32'd8);
        check({tag, " diff"}, {24'd0, got_diff}, {24'd0, exp_diff});
        check({tag, " bout"}, {31'd0, got_bout}, {31'd0, exp_bout});
        check({tag, " diff_held"}, {24'd0, diff}, {24'd0, exp_diff});
        check({tag, " bout_held"}, {31'd0, bout}, {31'd0, exp_bout});
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        check({tag, " ovf"}, {31'd0, got_ovf}, {31'd0, exp_ovf});
`endif
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset diff", {24'd0, diff}, 32'd0);
        check("reset bout", {31'd0, bout}, 32'd0);
        rst = 1'b0;

        run_op("100-37",   8'd100, 8'd37,  8'd63,  1'b0, 1'b0, 1'b0);
        run_op("5-10",     8'd5,   8'd10,  8'hFB,  1'b1, 1'b0, 1'b0);
        run_op("0-0",      8'h00,  8'h00,  8'h00,  1'b0, 1'b0, 1'b0);
        run_op("FF-FF",    8'hFF,  8'hFF,  8'h00,  1'b0, 1'b0, 1'b0);
        run_op("0-1",      8'h00,  8'h01,  8'hFF,  1'b1, 1'b0, 1'b0);
        run_op("restart",  8'd100, 8'd37,  8'd63,  1'b0, 1'b0, 1'b1);

        // Abort after the third shift edge
        @(negedge clk);
        a     = 8'hAA;
        b     = 8'h11;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("abort busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort diff", {24'd0, diff}, 32'd0);
        check("abort bout", {31'd0, bout}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort idle", {30'd0, busy, done}, 32'd0);

        run_op("200-55",   8'd200, 8'd55,  8'd145, 1'b0, 1'b0, 1'b0);
        run_op("80-01",    8'h80,  8'h01,  8'h7F,  1'b0, 1'b1, 1'b0);
        run_op("10-01",    8'h10,  8'h01,  8'h0F,  1'b0, 1'b0, 1'b0);
        run_op("01-80",    8'h01,  8'h80,  8'h81,  1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
